// File: rtl/hex_tx_pkg.sv
// ============================================================================
// hex_tx_pkg: shared state encoding, ASCII constants and nibble conversion
// Rev 1.0
// ============================================================================
`default_nettype none

package hex_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHAR = 3'd1,
    SEP  = 3'd2,
    CR   = 3'd3,
    LF   = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Uppercase hex digit: '0'..'9' then 'A'..'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2ascii.sv
// ============================================================================
// bin2ascii: combinational binary-to-ASCII-hex, one output byte per nibble
// Rev 1.0
// ============================================================================
`default_nettype none

module bin2ascii
  import hex_tx_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic [NBYTES*8-1:0]  bin,
  output logic [NBYTES*16-1:0] ascii
);

  // Output byte i holds the character for nibble i (byte 0 = least significant)
  for (genvar i = 0; i < NBYTES * 2; i++) begin : g_nib
    assign ascii[i*8 +: 8] = nib2ascii(bin[i*4 +: 4]);
  end

endmodule

`default_nettype wire

// File: rtl/hex_tx_sequencer.sv
// ============================================================================
// hex_tx_sequencer: streams 16-bit words as uppercase hex text lines to a byte sink
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_tx_sequencer
  import hex_tx_pkg::*;
#(
  parameter int         WORDS_PER_LINE = 8,
  parameter logic [7:0] SEP_CHAR       = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam logic [7:0] LAST_CNT = 8'(WORDS_PER_LINE - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] word_reg;
  logic [7:0]  word_cnt;
  logic [1:0]  nib_idx;
  logic        flush_pend;
  logic [31:0] ascii;

  logic        xfer;
  logic        accept;
  logic        flush_req;

  assign xfer      = tx_valid & tx_ready;
  assign accept    = in_valid & in_ready;
  assign flush_req = flush | flush_pend;

  bin2ascii #(
    .NBYTES (2)
  ) u_bin2ascii (
    .bin   (word_reg),
    .ascii (ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = CHAR;
        end else if (flush_req && (word_cnt != 8'd0)) begin
          state_nx = CR;
        end
      end
      CHAR: begin
        if (xfer && (nib_idx == 2'd0)) begin
          state_nx = (word_cnt == LAST_CNT) ? CR : SEP;
        end
      end
      SEP: begin
        if (xfer) begin
          state_nx = IDLE;
        end
      end
      CR: begin
        if (xfer) begin
          state_nx = LF;
        end
      end
      LF: begin
        if (xfer) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so they hold while the sink stalls
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      CHAR: begin
        tx_valid = 1'b1;
        tx_data  = ascii[{nib_idx, 3'b000} +: 8];
      end
      SEP: begin
        tx_valid = 1'b1;
        tx_data  = SEP_CHAR;
      end
      CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
    // A same-cycle flush blocks acceptance so the line is closed first
    in_ready = (state == IDLE) && !flush_pend && !flush && !rst;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg   <= 16'h0000;
      word_cnt   <= 8'd0;
      nib_idx    <= 2'd3;
      flush_pend <= 1'b0;
    end else begin
      if (accept) begin
        word_reg <= in_data;
        nib_idx  <= 2'd3;
      end

      if ((state == CHAR) && xfer && (nib_idx != 2'd0)) begin
        nib_idx <= nib_idx - 2'd1;
      end

      if ((state == SEP) && xfer) begin
        word_cnt <= word_cnt + 8'd1;
      end else if ((state == LF) && xfer) begin
        word_cnt <= 8'd0;
      end

      if ((state == LF) && xfer) begin
        flush_pend <= 1'b0;
      end else if ((state == IDLE) && flush_req && (word_cnt == 8'd0)) begin
        flush_pend <= 1'b0;
      end else if ((state != IDLE) && flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_tx_sequencer.sv
// ============================================================================
// tb_hex_tx_sequencer: scoreboard bench for hex_tx_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_tx_sequencer;

  localparam int WPL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_cnt = 0;
  bit          bp_mode = 1'b0;
  logic [7:0]  exp_q[$];
  int          xfer_cyc[$];
  int          last_lf_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  mon_exp;

  hex_tx_sequencer #(
    .WORDS_PER_LINE (WPL),
    .SEP_CHAR       (8'h20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte monitor: pops the scoreboard on each transfer and checks hold-while-stalled
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
        errors++;
        $display("FAIL hold: tx_valid=%b tx_data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
      end
    end
    if (!rst && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte: got %h, required no byte", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_byte: got %h, required %h", tx_data, mon_exp);
        end
      end
      xfer_cyc.push_back(cyc);
      if (tx_data == 8'h0A) last_lf_cyc = cyc;
    end
    prev_stall = !rst && tx_valid === 1'b1 && tx_ready !== 1'b1;
    prev_data  = tx_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexc(w[i*4 +: 4]));
    if (m_cnt == WPL - 1) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt = 0;
    end else begin
      exp_q.push_back(8'h20);
      m_cnt++;
    end
  endtask

  // Returns one cycle after acceptance, #1 after the posedge
  task automatic send_word(input logic [15:0] w, output int acc);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
      acc = -1;
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    push_word(w);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, required pending=0 busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    bp_mode = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    xfer_cyc.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: valid=%b data=%h, required 0 00", tx_valid, tx_data);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
    checks++;
    if (dut.word_cnt !== 8'd0 || dut.nib_idx !== 2'd3 || dut.flush_pend !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: word_cnt=%0d nib_idx=%0d flush_pend=%b, required 0 3 0",
               dut.word_cnt, dut.nib_idx, dut.flush_pend);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_single_word();
    int acc;
    do_reset();
    send_word(16'h12AF, acc);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (k == 6)) begin
        errors++;
        $display("FAIL single_in_ready: cycle+%0d in_ready=%b, required %b", k, in_ready, (k == 6));
      end
    end
    drain();
    checks++;
    if (xfer_cyc.size() != 5) begin
      errors++;
      $display("FAIL single_count: bytes=%0d, required 5", xfer_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (xfer_cyc[i] != acc + 1 + i) begin
          errors++;
          $display("FAIL single_timing: byte %0d at cycle %0d, required %0d", i, xfer_cyc[i], acc + 1 + i);
        end
      end
    end
  endtask

  task automatic test_full_line();
    int acc;
    do_reset();
    for (int i = 0; i < 8; i++) send_word(16'(i), acc);
    drain();
    checks++;
    if (dut.word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL line_wrap: word_cnt=%0d, required 0", dut.word_cnt);
    end
    send_word(16'hFFFF, acc);
    drain();
    checks++;
    if (dut.word_cnt !== 8'd1) begin
      errors++;
      $display("FAIL line_next: word_cnt=%0d, required 1", dut.word_cnt);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    bp_mode = 1'b1;
    send_word(16'hBEEF, acc);
    drain();
    send_word(16'h0A5C, acc);
    drain();
    bp_mode = 1'b0;
  endtask

  task automatic test_flush_mid_word();
    int acc;
    int acc2;
    do_reset();
    send_word(16'h1111, acc);
    send_word(16'h2222, acc);
    send_word(16'h3333, acc);
    @(posedge clk);
    #1;
    flush = 1'b1;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_cnt = 0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    send_word(16'h4444, acc2);
    checks++;
    if (acc2 != last_lf_cyc + 1) begin
      errors++;
      $display("FAIL flush_gate: accepted at cycle %0d, required %0d (after LF)", acc2, last_lf_cyc + 1);
    end
    drain();
  endtask

  task automatic test_flush_idle();
    int acc;
    do_reset();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle_quiet: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
      end
    end
    checks++;
    if (dut.flush_pend !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_clear: flush_pend=%b in_ready=%b, required 0 1", dut.flush_pend, in_ready);
    end
    for (int i = 0; i < 7; i++) send_word(16'hA000 + 16'(i), acc);
    send_word(16'hC0DE, acc);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drain();
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_eol_extra: tx_valid=%b data=%h, required valid=0", tx_valid, tx_data);
      end
    end
    checks++;
    if (dut.flush_pend !== 1'b0 || dut.word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL flush_eol_state: flush_pend=%b word_cnt=%0d, required 0 0", dut.flush_pend, dut.word_cnt);
    end
  endtask

  task automatic test_reset_mid_word();
    int acc;
    do_reset();
    send_word(16'hA5A5, acc);
    drain();
    send_word(16'h5A5A, acc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: tx_valid=%b busy=%b in_ready=%b, required 0 0 1", tx_valid, busy, in_ready);
    end
    send_word(16'h00C3, acc);
    drain();
    checks++;
    if (dut.word_cnt !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_count: word_cnt=%0d, required 1", dut.word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_line();
    test_backpressure();
    test_flush_mid_word();
    test_flush_idle();
    test_reset_mid_word();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_tx_sequencer.md
Name: hex_tx_sequencer

Overview:
- Streams 16-bit values as uppercase ASCII hex text, one byte at a time, to a byte sink such as the UART TX or an on-screen text buffer.
- Per word it emits 4 hex characters MSB-nibble first, then a separator.
- After WORDS_PER_LINE words it emits CR LF instead of the separator.
- Sits between keyboard/debug data producers and the character output path. It owns the sequencing of the existing combinational bin2ascii converter.

Parameters:
- WORDS_PER_LINE, 8, words per text line before CR LF is emitted (1..255).
- SEP_CHAR, 8'h20, separator byte emitted after each word that does not end a line.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  16  word to print.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- flush  in  1  single-cycle request to end the current line early.
- tx_data  out  8  output ASCII byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts tx_data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, tx_valid=0, tx_data=8'h00, in_ready=0, busy=0, word_cnt=0, flush_pend=0, nib_idx=3.
  - in_ready rises on the first cycle after rst is released.
- Input handshake:
  - in_ready=1 only in IDLE, and only when flush_pend=0.
  - A word is accepted when in_valid & in_ready. It is latched into word_reg, and the FSM moves to CHAR with nib_idx=3.
- Output handshake:
  - A byte transfers on tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid is never withdrawn before the byte transfers.
- Latency and throughput:
  - The first character is valid the cycle after the word is accepted.
  - With tx_ready tied high, one byte is emitted per cycle.
  - Each word takes 5 bytes (or 6 with CR LF) plus 1 IDLE cycle.
- Character conversion:
  - Nibble 0–9 maps to 8'h30+n.
  - Nibble A–F maps to 8'h37+n (uppercase).
  - Conversion uses bin2ascii on word_reg; the FSM selects byte nib_idx.
- FSM states:
  - IDLE:
    - On accept → CHAR.
    - Else if flush_pend or flush, and word_cnt≠0 → CR.
    - Else if flush_pend or flush, and word_cnt=0 → clear flush_pend, stay in IDLE.
  - CHAR:
    - Emits the char of nibble nib_idx.
    - On transfer with nib_idx>0: decrement nib_idx.
    - On transfer with nib_idx=0 and word_cnt=WORDS_PER_LINE-1 → CR.
    - On transfer with nib_idx=0 otherwise → SEP.
  - SEP:
    - Emits SEP_CHAR.
    - On transfer: word_cnt+=1 → IDLE.
  - CR:
    - Emits 8'h0D.
    - On transfer → LF.
  - LF:
    - Emits 8'h0A.
    - On transfer: word_cnt=0, flush_pend=0 → IDLE.
- Flush:
  - A flush pulse in any state other than IDLE sets flush_pend. It is serviced on the next IDLE entry, before any new word is accepted.
  - If the line ends naturally while flush_pend is set (the CR LF path), the LF transfer clears flush_pend. No extra CR LF is emitted.
  - flush together with in_valid in IDLE: flush takes priority because in_ready is gated. The word is accepted after LF.
- Counters:
  - word_cnt is 8 bits and never exceeds WORDS_PER_LINE-1.
  - nib_idx is 2 bits.
- Reset mid-operation: any partial word or line is abandoned. No remaining bytes are emitted.
- busy = (state≠IDLE).

Decomposition:
- Shared package hex_tx_pkg holds:
  - the state enum: IDLE, CHAR, SEP, CR, LF;
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_SP=8'h20.
- One sub-module: the existing bin2ascii instance (NBYTES=2) for the nibble-to-ASCII conversion. No other sub-modules.

Test Plan:
- Word 16'h12AF with tx_ready=1 and WORDS_PER_LINE=8 → bytes 31 32 41 46 20 on consecutive cycles. in_ready returns high 1 cycle after the 20 transfers.
- 8 words 16'h0000..16'h0007 with WORDS_PER_LINE=8 → the 8th word is followed by 0D 0A (no 20), and word_cnt returns to 0. Word 16'hFFFF then yields 46 46 46 46 20.
- Random tx_ready backpressure (≈50% low) on word 16'hBEEF → stream 42 45 45 46 20. tx_data is stable on every cycle where tx_valid=1 and tx_ready=0.
- flush pulse during the 2nd char of the 3rd word → that word finishes with 20, then 0D 0A. No word is accepted until LF transfers.
- flush in IDLE with word_cnt=0 → no output and flush_pend clears. flush on the last word of a line → exactly one 0D 0A is emitted.
- rst asserted for 1 cycle mid-word (after 2 chars) → next cycle tx_valid=0 and busy=0. A new word 16'h00C3 gives 30 30 43 33 20 with the line count restarted.
